// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store request stage: alignment check, lane setup, req/gnt + rvalid bus with timeout
module lsu_mem_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_func3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic [2:0]  wb_func3,
    output logic [1:0]  wb_addr_lo,
    output logic        st_done,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    // Counter starts at 0, so the last permitted cycle is count 2**W-2 (2**W-1 cycles total).
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [2:0]           op_func3;
    logic [31:0]          op_addr;
    logic                 accept, misaligned, tmo_hit;
    logic [3:0]           be_nxt;
    logic [31:0]          wdata_nxt;

    assign ex_ready   = (state == S_IDLE);
    assign accept     = ex_valid & ex_ready & (ex_is_load | ex_is_store);
    assign misaligned = ((ex_func3[1:0] == 2'd1) & ex_addr[0]) |
                        (ex_func3[1] & (ex_addr[1:0] != 2'b00));
    assign tmo_hit    = (tmo_cnt == TMO_LAST);

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = ex_wdata;
        case (ex_func3[1:0])
            2'd0: begin
                be_nxt    = 4'b0001 << ex_addr[1:0];
                wdata_nxt = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                be_nxt    = 4'b0011 << ex_addr[1:0];
                wdata_nxt = {2{ex_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && !misaligned) state_nxt = S_REQ;
            S_REQ: begin
                if (dmem_gnt)     state_nxt = dmem_we ? S_IDLE : S_WAIT;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_WAIT: if (dmem_rvalid || tmo_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt      <= '0;
            op_func3     <= '0;
            op_addr      <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_rdata     <= '0;
            wb_func3     <= '0;
            wb_addr_lo   <= '0;
            st_done      <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            fault_addr   <= '0;
        end else begin
            wb_valid     <= 1'b0;
            st_done      <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            tmo_cnt      <= (state_nxt != state) ? '0 : tmo_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept && misaligned) begin
                        misalign_exc <= 1'b1;
                        fault_addr   <= ex_addr;
                    end else if (accept) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_is_store & ~ex_is_load;
                        dmem_addr  <= {ex_addr[31:2], 2'b00};
                        dmem_be    <= be_nxt;
                        dmem_wdata <= wdata_nxt;
                        op_func3   <= ex_func3;
                        op_addr    <= ex_addr;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        st_done  <= dmem_we;
                    end else if (tmo_hit) begin
                        dmem_req   <= 1'b0;
                        bus_err    <= 1'b1;
                        fault_addr <= op_addr;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid   <= 1'b1;
                        wb_rdata   <= dmem_rdata;
                        wb_func3   <= op_func3;
                        wb_addr_lo <= op_addr[1:0];
                    end else if (tmo_hit) begin
                        bus_err    <= 1'b1;
                        fault_addr <= op_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    localparam int TW = 3;
    localparam int EV_WB = 0, EV_ST = 1, EV_MIS = 2, EV_BERR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_func3;
    logic [31:0] ex_addr, ex_wdata;
    logic        dmem_req, dmem_gnt, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic [2:0]  wb_func3;
    logic [1:0]  wb_addr_lo;
    logic        st_done, misalign_exc, bus_err;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_func3(ex_func3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_func3(wb_func3), .wb_addr_lo(wb_addr_lo),
        .st_done(st_done), .misalign_exc(misalign_exc), .bus_err(bus_err), .fault_addr(fault_addr)
    );

    typedef struct {
        int          kind;
        logic [31:0] rdata;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] fa;
    } ev_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    ev_t  ev_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_ev(input int kind, input logic [31:0] rdata, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] fa);
        ev_t e;
        e.kind = kind; e.rdata = rdata; e.f3 = f3; e.lo = lo; e.fa = fa;
        ev_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        logic bad;
        checks++;
        if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL ev_unexpected: got event kind %0d, expected none", kind);
            return;
        end
        e = ev_q.pop_front();
        bad = (e.kind != kind);
        if (!bad && kind == EV_WB)
            bad = (wb_rdata !== e.rdata) || (wb_func3 !== e.f3) || (wb_addr_lo !== e.lo);
        if (!bad && (kind == EV_MIS || kind == EV_BERR))
            bad = (fault_addr !== e.fa);
        if (bad) begin
            errors++;
            $display("FAIL ev_kind%0d: got kind=%0d rdata=%h f3=%0d lo=%0d fa=%h, expected kind=%0d rdata=%h f3=%0d lo=%0d fa=%h",
                     kind, kind, wb_rdata, wb_func3, wb_addr_lo, fault_addr, e.kind, e.rdata, e.f3, e.lo, e.fa);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req && dmem_gnt) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got addr=%h, expected no request", dmem_addr);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    if (dmem_we !== b.we || dmem_addr !== b.addr || dmem_be !== b.be || dmem_wdata !== b.wdata) begin
                        errors++;
                        $display("FAIL bus_txn: got we=%b addr=%h be=%b wdata=%h, expected we=%b addr=%h be=%b wdata=%h",
                                 dmem_we, dmem_addr, dmem_be, dmem_wdata, b.we, b.addr, b.be, b.wdata);
                    end
                end
            end
            if (wb_valid)     check_ev(EV_WB);
            if (st_done)      check_ev(EV_ST);
            if (misalign_exc) check_ev(EV_MIS);
            if (bus_err)      check_ev(EV_BERR);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_func3 = f3; ex_addr = a; ex_wdata = d;
    endtask

    task automatic drop_op();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    // Holds gnt low for 'delay' request cycles, then grants; reports cycles dmem_req was seen high.
    task automatic grant(input int delay, output int req_cycles);
        int w;
        w = 0;
        req_cycles = 0;
        while (!dmem_req && w < 10) begin tick(); w++; end
        if (!dmem_req) begin
            checks++; errors++;
            $display("FAIL grant_wait: got dmem_req=0 after %0d cycles, expected 1", w);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            if (dmem_req) req_cycles++;
            tick();
        end
        if (dmem_req) req_cycles++;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
    endtask

    task automatic return_data(input logic [31:0] d);
        dmem_rvalid = 1'b1; dmem_rdata = d;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        ex_func3 = '0; ex_addr = '0; ex_wdata = '0;
        drop_op();
        repeat (3) tick();
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_pulses", {28'd0, wb_valid, st_done, misalign_exc, bus_err}, 32'd0);
        chk("rst_dmem", {31'd0, dmem_req} | dmem_addr | {28'd0, dmem_be} | dmem_wdata, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Neither load nor store flag: ignored.
        drive_op(1'b0, 1'b0, 3'd2, 32'h0000_0800, 32'h0);
        tick();
        drop_op();
        chk("ignored_ready", {31'd0, ex_ready}, 32'd1);
        chk("ignored_req", {31'd0, dmem_req}, 32'd0);

        // lb 0x1003
        push_bus(1'b0, 32'h0000_1000, 4'b1000, 32'h0);
        push_ev(EV_WB, 32'h80AB_CDEF, 3'd0, 2'd3, 32'h0);
        drive_op(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0);
        tick();
        drop_op();
        grant(0, n);
        return_data(32'h80AB_CDEF);
        chk("lb_wb_t3", {31'd0, wb_valid}, 32'd1);
        chk("lb_ready_t3", {31'd0, ex_ready}, 32'd1);
        tick();

        // sh 0x2002 with gnt held low 3 cycles
        push_bus(1'b1, 32'h0000_2000, 4'b1100, 32'h5678_5678);
        push_ev(EV_ST, 32'h0, 3'd0, 2'd0, 32'h0);
        drive_op(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h1234_5678);
        tick();
        drop_op();
        grant(3, n);
        chk("sh_req_cycles", n, 32'd4);
        chk("sh_st_done", {31'd0, st_done}, 32'd1);
        chk("sh_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("sh_ready", {31'd0, ex_ready}, 32'd1);
        tick();

        // sw 0x60 and sb 0x72
        push_bus(1'b1, 32'h0000_0060, 4'b1111, 32'h1122_3344);
        push_ev(EV_ST, 32'h0, 3'd0, 2'd0, 32'h0);
        drive_op(1'b0, 1'b1, 3'd2, 32'h0000_0060, 32'h1122_3344);
        tick();
        drop_op();
        grant(0, n);
        push_bus(1'b1, 32'h0000_0070, 4'b0100, 32'h5555_5555);
        push_ev(EV_ST, 32'h0, 3'd0, 2'd0, 32'h0);
        drive_op(1'b0, 1'b1, 3'd0, 32'h0000_0072, 32'hFFFF_FF55);
        tick();
        drop_op();
        grant(0, n);
        tick();

        // lw 0x3001 and lh 0x2005 misaligned
        push_ev(EV_MIS, 32'h0, 3'd0, 2'd0, 32'h0000_3001);
        drive_op(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0);
        tick();
        drop_op();
        chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_ready", {31'd0, ex_ready}, 32'd1);
        push_ev(EV_MIS, 32'h0, 3'd0, 2'd0, 32'h0000_2005);
        drive_op(1'b1, 1'b0, 3'd1, 32'h0000_2005, 32'h0);
        tick();
        drop_op();
        tick();

        // Load granted, no rvalid: timeout in WAIT
        push_bus(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
        push_ev(EV_BERR, 32'h0, 3'd0, 2'd0, 32'h0000_0100);
        drive_op(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0);
        tick();
        drop_op();
        grant(0, n);
        n = 0;
        while (!bus_err && n < 20) begin tick(); n++; end
        chk("tmo_wait_cycles", n, 32'd7);
        chk("tmo_ready", {31'd0, ex_ready}, 32'd1);
        tick(); tick();
        return_data(32'hDEAD_0000);
        chk("tmo_stray_rvalid", {31'd0, wb_valid}, 32'd0);

        // Back-to-back sb 0x40 then lhu 0x46 with ex_valid held high
        push_bus(1'b1, 32'h0000_0040, 4'b0001, 32'hAAAA_AAAA);
        push_ev(EV_ST, 32'h0, 3'd0, 2'd0, 32'h0);
        push_bus(1'b0, 32'h0000_0044, 4'b1100, 32'h0);
        push_ev(EV_WB, 32'hDEAD_BEEF, 3'd5, 2'd2, 32'h0);
        drive_op(1'b0, 1'b1, 3'd0, 32'h0000_0040, 32'h0000_00AA);
        tick();
        drive_op(1'b1, 1'b0, 3'd5, 32'h0000_0046, 32'h0);
        chk("b2b_busy", {31'd0, ex_ready}, 32'd0);
        grant(0, n);
        chk("b2b_ready_again", {31'd0, ex_ready}, 32'd1);
        tick();
        drop_op();
        grant(0, n);
        return_data(32'hDEAD_BEEF);
        tick();

        // Reset while in WAIT
        push_bus(1'b0, 32'h0000_0500, 4'b1111, 32'h0);
        drive_op(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0);
        tick();
        drop_op();
        grant(0, n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_req", {31'd0, dmem_req}, 32'd0);
        chk("rstw_pulses", {28'd0, wb_valid, st_done, misalign_exc, bus_err}, 32'd0);
        chk("rstw_ready", {31'd0, ex_ready}, 32'd1);
        return_data(32'h1111_2222);
        chk("rstw_stray_rvalid", {31'd0, wb_valid}, 32'd0);
        tick(); tick();

        chk("ev_q_empty", ev_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
